// File: rtl/pio_buttons_debounced.sv
// Avalon-MM input PIO: per-bit 2-FF synchroniser, counter debouncer,
// selectable rising/falling edge capture and a masked level interrupt.
module pio_buttons_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] settle;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_writedata;

  assign wr               = chipselect && !write_n;
  assign wdata            = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // A bit settles on the clock where it has disagreed with stable for the full hold time.
  always_comb begin
    settle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      settle[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise  = settle & s2 & rise_en;
  assign fall  = settle & ~s2 & fall_en;
  assign clear = (wr && address == ADDR_EDGE) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux = stable;
      ADDR_RAW:      rd_mux = s2;
      ADDR_IRQ_MASK: rd_mux = irq_mask;
      ADDR_EDGE:     rd_mux = edge_capture;
      ADDR_RISE_EN:  rd_mux = rise_en;
      ADDR_FALL_EN:  rd_mux = fall_en;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= in_port;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A new edge event overrides a simultaneous write-1-to-clear so no press is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear) | rise | fall;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_RISE_EN)  rise_en  <= wdata;
      if (wr && address == ADDR_FALL_EN)  fall_en  <= wdata;
      irq      <= |(edge_capture & irq_mask);
      readdata <= 32'(rd_mux);
    end
  end

endmodule

// File: tb/tb_pio_buttons_debounced.sv
// Scoreboard bench for pio_buttons_debounced: a sliding-window reference model
// predicts every read and the irq line while randomized and directed traffic runs.
module tb_pio_buttons_debounced;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          r_reset = 1'b0;
  logic [2:0]    addr = '0;
  logic          cs = 1'b0;
  logic          wn = 1'b1;
  logic [31:0]   wd = '0;
  logic [W-1:0]  pins = '0;
  logic          rd_req = 1'b0;
  logic [31:0]   readdata;
  logic          irq;

  pio_buttons_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(r_reset), .address(addr), .chipselect(cs),
    .write_n(wn), .writedata(wd), .in_port(pins),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  // Reference state: the synchroniser is a two-deep delay line and the debouncer
  // is a window of the last D synchronised samples that must all disagree with stable.
  logic [W-1:0] sync_q[$];
  logic [W-1:0] win_q[$];
  logic [W-1:0] m_stable, m_cap, m_mask, m_rise_en, m_fall_en;
  logic         m_irq = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_step();
    logic [W-1:0] s2_pre, upd, rise, fall, clr, view;
    logic         wr, all_diff;
    if (r_reset) begin
      sync_q.delete(); sync_q.push_back('0); sync_q.push_back('0);
      win_q.delete();
      m_stable = '0; m_cap = '0; m_mask = '0;
      m_rise_en = '1; m_fall_en = '0; m_irq = 1'b0;
      sb_q.push_back('{name: "reset_readdata", exp: 32'h0});
      return;
    end
    s2_pre = sync_q.pop_front();
    sync_q.push_back(pins);
    case (addr)
      3'd0: view = m_stable;
      3'd1: view = s2_pre;
      3'd2: view = m_mask;
      3'd3: view = m_cap;
      3'd4: view = m_rise_en;
      3'd5: view = m_fall_en;
      default: view = '0;
    endcase
    if (rd_req) sb_q.push_back('{name: $sformatf("read_a%0d", addr), exp: 32'(view)});
    win_q.push_back(s2_pre);
    if (win_q.size() > D) void'(win_q.pop_front());
    upd = '0;
    if (win_q.size() == D) begin
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (win_q[j][b] == m_stable[b]) all_diff = 1'b0;
        upd[b] = all_diff;
      end
    end
    wr   = cs && !wn;
    clr  = (wr && addr == 3'd3) ? wd[W-1:0] : '0;
    rise = upd & s2_pre & m_rise_en;
    fall = upd & ~s2_pre & m_fall_en;
    m_irq    = |(m_cap & m_mask);
    m_cap    = (m_cap & ~clr) | rise | fall;
    m_stable = m_stable ^ upd;
    if (wr && addr == 3'd2) m_mask    = wd[W-1:0];
    if (wr && addr == 3'd4) m_rise_en = wd[W-1:0];
    if (wr && addr == 3'd5) m_fall_en = wd[W-1:0];
  endtask

  task automatic applyStimulus(input logic rst, input logic [W-1:0] p, input logic c,
                               input logic w_n, input logic [2:0] a, input logic [31:0] d,
                               input logic rd);
    r_reset = rst; pins = p; cs = c; wn = w_n; addr = a; wd = d; rd_req = rd;
    @(posedge clk);
    model_step();
    #1;
    r_reset = 1'b0; cs = 1'b0; wn = 1'b1; rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, pins, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b0, pins, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic bus_read(input logic [2:0] a);
    applyStimulus(1'b0, pins, 1'b0, 1'b1, a, 32'h0, 1'b1);
  endtask

  // Monitor: every cycle checks irq, and drains any read responses due this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e.name, readdata, e.exp);
      end
    end
  end

  initial begin
    logic [W-1:0] np;
    int op;
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b1);
    started = 1;

    // Basic press on bit0 with interrupt enabled
    bus_write(3'd2, 32'h1);
    pins = 4'b0001;
    for (int k = 0; k < 8; k++) bus_read(3'd0);
    bus_read(3'd3);
    idle(2);

    // Glitch of 3 clocks is rejected, 4 clocks is accepted
    pins = 4'b0011; idle(3); pins = 4'b0001; idle(8);
    bus_read(3'd0); bus_read(3'd3);
    pins = 4'b0011; idle(4); pins = 4'b0001; idle(8);
    bus_read(3'd0); bus_read(3'd3);

    // Falling-edge mode on bit2
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    bus_write(3'd4, 32'h0); bus_write(3'd5, 32'h4);
    pins = 4'b0100; idle(10); bus_read(3'd3);
    pins = 4'b0000; idle(10); bus_read(3'd3); bus_read(3'd5);

    // Clear colliding with a fresh rising edge on bit0, then a clean clear
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    bus_write(3'd2, 32'h1);
    pins = 4'b0001; idle(8);
    pins = 4'b0000; idle(8);
    pins = 4'b0001; idle(5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3); idle(2);
    bus_write(3'd3, 32'h1); bus_read(3'd3); idle(2);

    // Reset in the middle of a bit3 debounce
    pins = 4'b1000; idle(4);
    applyStimulus(1'b1, pins, 1'b0, 1'b1, 3'd3, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) bus_read(3'd0);
    bus_read(3'd4);

    // Unused addresses and RAW latency
    bus_write(3'd6, 32'hFFFF_FFFF); bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd6); bus_read(3'd7);
    pins = 4'b0110;
    for (int k = 0; k < 4; k++) bus_read(3'd1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      np = pins;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) np[b] = ~np[b];
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 599) == 0)
        applyStimulus(1'b1, np, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 32'h0, 1'b1);
      else if (op < 4)
        applyStimulus(1'b0, np, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 32'h0, 1'b1);
      else if (op == 4)
        applyStimulus(1'b0, np, 1'b1, 1'b0, 3'd3, $urandom(), 1'b1);
      else if (op == 5)
        applyStimulus(1'b0, np, 1'b1, 1'b0, 3'd2, $urandom(), 1'b0);
      else if (op == 6)
        applyStimulus(1'b0, np, 1'b1, 1'b0, 3'($urandom_range(4, 5)), $urandom(), 1'b0);
      else if (op == 7)
        applyStimulus(1'b0, np, 1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom(), 1'b1);
      else
        applyStimulus(1'b0, np, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
